cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Consumer end of the functional-unit result interface.
- Accepts per-FU cdb_t completion packets from the execute stage (add, mul, div, br), buffers each source in a small FIFO, and drives one broadcast per cycle onto the single common data bus.
- The common data bus feeds the ROB, reservation stations and physical regfile.
- Back-pressures each FU through a per-source ready, and flushes all buffered results on global_branch_signal.

Parameters:
- NUM_SRC, 4, number of result sources; index 0=add, 1=mul, 2=div, 3=br.
- FIFO_DEPTH, 2, entries per source FIFO; power of two, >=2.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- cdb_in  input  NUM_SRC x cdb_t  per-source result packet; cdb_in[i].valid marks a completion this cycle
- src_ready  output  NUM_SRC  source i may present a valid packet this cycle
- global_branch_signal  input  1  mispredict flush
- cdb_out  output  cdb_t  broadcast packet; cdb_out.valid qualifies it
- grant_idx  output  $clog2(NUM_SRC)  source index driving cdb_out; 0 when cdb_out.valid=0
- busy  output  1  any FIFO non-empty

Behaviour:
- Reset (async, rst=1):
  - All FIFO counts, head and tail pointers are 0.
  - rr_ptr is 0.
  - Outputs during and after reset: cdb_out='0, grant_idx=0, busy=0, src_ready=all 1s.
  - Reset asserted mid-operation discards all buffered packets immediately, without waiting for a clock edge.
- Per-source FIFO:
  - src_ready[i] = (count[i] != FIFO_DEPTH), derived from the registered count only; a same-cycle dequeue does not raise it.
  - Enqueue at the clock edge when cdb_in[i].valid && src_ready[i] && !global_branch_signal.
  - Packet stored unmodified.
  - cdb_in[i].valid while src_ready[i]=0 is a protocol violation: the packet is dropped and a bench assertion fires.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous enqueue and dequeue on the same FIFO leaves count unchanged.
- Arbitration (combinational, round-robin):
  - Search sources rr_ptr, rr_ptr+1, ... modulo NUM_SRC; first non-empty FIFO wins.
  - cdb_out = head packet of the winner with valid=1; grant_idx = winner.
  - Winner dequeues at the edge.
  - rr_ptr <= (winner+1) mod NUM_SRC on a grant; unchanged when no FIFO is non-empty.
  - Nothing pending: cdb_out='0, grant_idx=0.
- Latency:
  - Packet valid at input in cycle C appears on cdb_out no earlier than C+1; no combinational bypass.
  - With no contention, exactly C+1.
- Throughput: one broadcast per cycle total; per-source order is strictly FIFO.
- Flush (global_branch_signal=1 in cycle C):
  - cdb_out='0 and grant_idx=0 during C.
  - No dequeue; all cdb_in packets in C are ignored.
  - At the edge all counts and pointers clear to 0 and rr_ptr<=0.
  - Cycle C+1: busy=0, src_ready all 1.
- busy = OR of (count[i]!=0), from registered state.
- A packet is never duplicated or reordered within a source.

Test Plan:
1. Reset, then cdb_in[0].valid=1 with rob_idx=5, rd_v=0x1234 for one cycle -> cycle+1: cdb_out.valid=1, rob_idx=5, rd_v=0x1234, grant_idx=0; cycle+2: cdb_out.valid=0, busy=0.
2. All four sources valid in one cycle, rob_idx 10..13, rr_ptr=0 -> broadcasts in cycles +1..+4 carry rob_idx 10, 11, 12, 13 with grant_idx 0, 1, 2, 3; rr_ptr ends at 0.
3. Source 1 (mul) held valid 3 consecutive cycles while the others are idle but source 2 keeps one entry queued -> grants alternate 1, 2, 1, ...; no source waits more than NUM_SRC-1 cycles.
4. Block output by keeping sources 0, 2, 3 busy and fill source 3 with 2 packets -> src_ready[3]=0 the cycle after the 2nd enqueue; src_ready[3] returns 1 the cycle after its first dequeue; injecting valid while not ready triggers the assertion.
5. Three entries buffered across sources, then global_branch_signal=1 with cdb_in[0].valid=1 in the same cycle -> cdb_out='0 that cycle; next cycle busy=0, src_ready=4'b1111, and nothing from before or during the flush is ever broadcast.
6. rst asserted asynchronously mid-cycle with 2 entries queued -> cdb_out='0 and busy=0 immediately, before the next clk edge; after release, a new packet is broadcast with normal 1-cycle latency.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: buffers per-FU completion packets in small FIFOs
// and broadcasts one packet per cycle with round-robin fairness.
package cdb_pkg;
  typedef struct packed {
    logic        valid;
    logic [5:0]  rob_idx;
    logic [31:0] rd_v;
  } cdb_t;
endpackage

// One source FIFO; enq/deq arrive pre-qualified from the arbiter.
module cdb_src_fifo
  import cdb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic enq,
  input  logic deq,
  input  cdb_t din,
  output cdb_t head,
  output logic empty,
  output logic full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  cdb_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through a non-zero count.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
endmodule

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  cdb_t [NUM_SRC-1:0]           cdb_in,
  output logic [NUM_SRC-1:0]           src_ready,
  input  logic                         global_branch_signal,
  output cdb_t                         cdb_out,
  output logic [$clog2(NUM_SRC)-1:0]   grant_idx,
  output logic                         busy
);
  localparam int IW = $clog2(NUM_SRC);

  cdb_t [NUM_SRC-1:0] heads;
  logic [NUM_SRC-1:0] empty, full, enq, deq;
  logic [IW-1:0]      rr_ptr, winner;
  logic               found, grant;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign enq[g] = cdb_in[g].valid && src_ready[g] && !global_branch_signal;
    assign deq[g] = grant && (winner == IW'(g));
    cdb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (global_branch_signal),
      .enq   (enq[g]),
      .deq   (deq[g]),
      .din   (cdb_in[g]),
      .head  (heads[g]),
      .empty (empty[g]),
      .full  (full[g])
    );
  end

  assign src_ready = ~full;
  assign busy      = |(~empty);

  // Round-robin search starting at rr_ptr; first non-empty source wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_SRC;
      if (!found && !empty[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  assign grant = found && !global_branch_signal;

  always_comb begin
    cdb_out   = '0;
    grant_idx = '0;
    if (grant) begin
      cdb_out       = heads[winner];
      cdb_out.valid = 1'b1;
      grant_idx     = winner;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       rr_ptr <= '0;
    else if (global_branch_signal) rr_ptr <= '0;
    else if (grant)                rr_ptr <= (winner == IW'(NUM_SRC - 1)) ? '0 : winner + 1'b1;
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed stimulus pushes expected broadcasts,
// a negedge monitor pops and compares them.
module tb_cdb_arbiter;
  import cdb_pkg::*;
  localparam int NS = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              gbs = 1'b0;
  cdb_t [NS-1:0]     cdb_in;
  logic [NS-1:0]     src_ready;
  cdb_t              cdb_out;
  logic [1:0]        grant_idx;
  logic              busy;

  int errs = 0;
  int chks = 0;
  int viol = 0;

  typedef struct {
    int          rob;
    logic [31:0] rd;
    int          gi;
  } exp_t;
  exp_t q[$];

  cdb_arbiter #(.NUM_SRC(NS), .FIFO_DEPTH(2)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .cdb_in               (cdb_in),
    .src_ready            (src_ready),
    .global_branch_signal (gbs),
    .cdb_out              (cdb_out),
    .grant_idx            (grant_idx),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic put(input int s, input int rob, input logic [31:0] rd);
    cdb_in[s].valid   = 1'b1;
    cdb_in[s].rob_idx = 6'(rob);
    cdb_in[s].rd_v    = rd;
  endtask

  task automatic expect_b(input int rob, input logic [31:0] rd, input int gi);
    exp_t e;
    e.rob = rob; e.rd = rd; e.gi = gi;
    q.push_back(e);
  endtask

  task automatic edge_clr();
    @(posedge clk);
    #1;
    cdb_in = '0;
    gbs    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) edge_clr();
  endtask

  // Monitor: every broadcast must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && cdb_out.valid) begin
      if (q.size() == 0) begin
        check("unexpected_bcast", {26'd0, cdb_out.rob_idx, cdb_out.rd_v}, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("bcast", {24'd0, cdb_out.rob_idx, cdb_out.rd_v, 2'(grant_idx)},
              {24'd0, 6'(e.rob), e.rd, 2'(e.gi)});
      end
    end
  end

  // Protocol watch: valid presented while the source is not ready.
  always @(negedge clk) begin
    for (int i = 0; i < NS; i++)
      if (!rst && cdb_in[i].valid && !src_ready[i]) viol++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cdb_in = '0;
    #1 rst = 1'b1;
    #2;
    check("rst_cdb_out", 64'(cdb_out), 64'd0);
    check("rst_grant", 64'(grant_idx), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(src_ready), 64'hF);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: single packet, one-cycle latency, no bypass
    put(0, 5, 32'h1234);
    expect_b(5, 32'h1234, 0);
    @(negedge clk);
    check("t1_no_bypass", 64'(cdb_out.valid), 64'd0);
    edge_clr();
    @(negedge clk);
    check("t1_valid", 64'(cdb_out.valid), 64'd1);
    check("t1_grant", 64'(grant_idx), 64'd0);
    edge_clr();
    @(negedge clk);
    check("t1_drained", 64'(cdb_out.valid), 64'd0);
    check("t1_busy", 64'(busy), 64'd0);

    // 2: all four sources at once from rr_ptr=0
    gbs = 1'b1;
    edge_clr();
    for (int i = 0; i < NS; i++) begin
      put(i, 10 + i, 32'h100 + i);
      expect_b(10 + i, 32'h100 + i, i);
    end
    edge_clr();
    idle(4);
    @(negedge clk);
    check("t2_busy", 64'(busy), 64'd0);
    // rr_ptr back at 0: source 0 beats source 1
    put(0, 14, 32'h14); put(1, 15, 32'h15);
    expect_b(14, 32'h14, 0); expect_b(15, 32'h15, 1);
    edge_clr();
    idle(3);

    // 3: mul streaming while div keeps an entry queued
    gbs = 1'b1;
    edge_clr();
    expect_b(20, 32'h20, 1); expect_b(30, 32'h30, 2); expect_b(21, 32'h21, 1);
    expect_b(31, 32'h31, 2); expect_b(22, 32'h22, 1);
    put(1, 20, 32'h20); put(2, 30, 32'h30);
    edge_clr();
    put(1, 21, 32'h21);
    edge_clr();
    put(1, 22, 32'h22); put(2, 31, 32'h31);
    edge_clr();
    idle(5);

    // 4: fill source 3, back-pressure, dropped violation packet
    expect_b(42, 32'h42, 2); expect_b(50, 32'h50, 3); expect_b(40, 32'h40, 0);
    expect_b(43, 32'h43, 2); expect_b(51, 32'h51, 3); expect_b(41, 32'h41, 0);
    put(0, 40, 32'h40); put(2, 42, 32'h42); put(3, 50, 32'h50);
    edge_clr();
    put(0, 41, 32'h41); put(2, 43, 32'h43); put(3, 51, 32'h51);
    edge_clr();
    put(3, 63, 32'hDEAD);
    @(negedge clk);
    check("t4_full", 64'(src_ready[3]), 64'd0);
    edge_clr();
    @(negedge clk);
    check("t4_ready_back", 64'(src_ready[3]), 64'd1);
    idle(6);
    check("t4_viol", 64'(viol), 64'd1);

    // 5: flush with packets buffered and a same-cycle input
    put(0, 60, 32'h60); put(1, 61, 32'h61); put(2, 62, 32'h62);
    edge_clr();
    gbs = 1'b1;
    put(0, 33, 32'h33);
    @(negedge clk);
    check("t5_flush_out", 64'(cdb_out), 64'd0);
    check("t5_flush_grant", 64'(grant_idx), 64'd0);
    check("t5_busy_before", 64'(busy), 64'd1);
    edge_clr();
    @(negedge clk);
    check("t5_busy_after", 64'(busy), 64'd0);
    check("t5_ready_after", 64'(src_ready), 64'hF);
    idle(4);

    // 6: asynchronous reset with entries queued
    put(0, 7, 32'h70); put(1, 8, 32'h71);
    edge_clr();
    #2 rst = 1'b1;
    #1;
    check("t6_async_out", 64'(cdb_out), 64'd0);
    check("t6_async_busy", 64'(busy), 64'd0);
    check("t6_async_ready", 64'(src_ready), 64'hF);
    @(posedge clk);
    #1 rst = 1'b0;
    put(2, 9, 32'hBEEF);
    expect_b(9, 32'hBEEF, 2);
    @(negedge clk);
    check("t6_no_bypass", 64'(cdb_out.valid), 64'd0);
    edge_clr();
    @(negedge clk);
    check("t6_valid", 64'(cdb_out.valid), 64'd1);
    check("t6_grant", 64'(grant_idx), 64'd2);
    idle(3);

    check("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
